spi_ram_loader: RTL

- SPI slave that sits upstream of manchester_baby and ram_5x32 and owns the RAM port mux between the host SPI link and the Baby core.
- Lets an external host load and read back the 32x32 store, then release the Baby to run; the Baby is held in reset while the loader owns the RAM.
- All SPI pins are treated as asynchronous and oversampled by sys_clock_i.

---
 rtl/spi_ram_loader.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/spi_ram_loader.sv
// spi_ram_loader
//   SPI slave (mode 0, MSB first) that lets a host load and read back the
//   32x32 store shared with the Baby core, and owns the RAM port mux.
//   The Baby is held in reset while the loader owns the RAM (run = 0).
//
// Ports
//   sys_clock_i      system clock (RAM / Baby domain)
//   reset_n_i        asynchronous active-low reset
//   spi_clock_i      SCK, asynchronous, oversampled (>= 8x)
//   spi_cs_i         chip select, active low, asynchronous
//   spi_pico_i       host data in, asynchronous
//   spi_poci_o       data out to host
//   baby_ram_*_i     Baby RAM port, passed through when running
//   baby_stop_i      Baby stop lamp, readable via control register
//   baby_reset_o     reset to the Baby (= ~run)
//   ram_addr_o/ram_data_o/ram_we_o   to ram_5x32
//   ram_data_i       from ram_5x32, valid 2 cycles after address
module spi_ram_loader #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        sys_clock_i,
    input  logic        reset_n_i,
    input  logic        spi_clock_i,
    input  logic        spi_cs_i,
    input  logic        spi_pico_i,
    output logic        spi_poci_o,
    input  logic [4:0]  baby_ram_addr_i,
    input  logic [31:0] baby_ram_data_i,
    input  logic        baby_ram_we_i,
    input  logic        baby_stop_i,
    output logic        baby_reset_o,
    output logic [4:0]  ram_addr_o,
    output logic [31:0] ram_data_o,
    output logic        ram_we_o,
    input  logic [31:0] ram_data_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WDATA,
        S_DUMMY,
        S_COMMIT,
        S_RDATA,
        S_WAIT
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, pico_sync;
    logic        sck_prev;
    logic        sck_s, cs_s, pico_s;
    logic        rise, fall;

    logic [5:0]  bit_cnt;
    logic [30:0] rx;        // bit 31 of the shift is never needed; the 32nd bit is taken live
    logic [6:0]  cmd;       // type bits [6:5], address [4:0]
    logic [31:0] tx;
    logic        run;
    logic        poci;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic        ld_we;

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign pico_s = pico_sync[SYNC_STAGES-1];
    assign rise   = sck_s & ~sck_prev;
    assign fall   = ~sck_s & sck_prev;

    always_ff @(posedge sys_clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            pico_sync <= '0;
            sck_prev  <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_clock_i};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_i};
            pico_sync <= {pico_sync[SYNC_STAGES-2:0], spi_pico_i};
            sck_prev  <= sck_s;
        end
    end

    always_ff @(posedge sys_clock_i or negedge reset_n_i) begin
        if (!reset_n_i) state <= S_IDLE;
        else            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (cs_s) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   state_next = S_CMD;
                S_CMD:    if (rise && bit_cnt == 6'd7)  state_next = rx[6] ? S_WDATA : S_DUMMY;
                S_WDATA:  if (rise && bit_cnt == 6'd39) state_next = S_COMMIT;
                S_DUMMY:  if (rise && bit_cnt == 6'd15) state_next = S_RDATA;
                S_COMMIT: state_next = S_WAIT;
                S_RDATA:  if (rise && bit_cnt == 6'd47) state_next = S_WAIT;
                S_WAIT:   state_next = S_WAIT;
                default:  state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            bit_cnt <= '0;
            rx      <= '0;
            cmd     <= '0;
            tx      <= '0;
            run     <= 1'b0;
            poci    <= 1'b0;
            ld_addr <= '0;
            ld_data <= '0;
            ld_we   <= 1'b0;
        end else begin
            ld_we <= 1'b0;

            if (cs_s) begin
                bit_cnt <= '0;
            end else if (rise) begin
                rx <= {rx[29:0], pico_s};
                if (bit_cnt != 6'd48) bit_cnt <= bit_cnt + 6'd1;
            end

            // Command byte complete: latch it and present the read address
            // early so the RAM has the whole dummy byte to respond.
            if (state == S_CMD && rise && bit_cnt == 6'd7) begin
                cmd     <= {rx[5:0], pico_s};
                ld_addr <= {rx[3:0], pico_s};
            end

            // 40th bit: commit on the same edge so a following CS high
            // cannot cancel a fully received write.
            if (state == S_WDATA && rise && bit_cnt == 6'd39) begin
                if (cmd[6:5] == 2'b00 && !run) begin
                    ld_we   <= 1'b1;
                    ld_addr <= cmd[4:0];
                    ld_data <= {rx, pico_s};
                end else if (cmd[6:5] == 2'b01) begin
                    run <= pico_s;
                end
            end

            if (state == S_DUMMY && rise && bit_cnt == 6'd15) begin
                case (cmd[6:5])
                    2'b00:   tx <= run ? '0 : ram_data_i;
                    2'b01:   tx <= {30'b0, baby_stop_i, run};
                    default: tx <= '0;
                endcase
            end

            if (cs_s) begin
                poci <= 1'b0;
            end else if (fall) begin
                if (state == S_RDATA) begin
                    poci <= tx[31];
                    tx   <= {tx[30:0], 1'b0};
                end else begin
                    poci <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        if (run) begin
            ram_addr_o = baby_ram_addr_i;
            ram_data_o = baby_ram_data_i;
            ram_we_o   = baby_ram_we_i;
        end else begin
            ram_addr_o = ld_addr;
            ram_data_o = ld_data;
            ram_we_o   = ld_we;
        end
    end

    assign baby_reset_o = ~run;
    assign spi_poci_o   = poci;

endmodule
